// File: rtl/event_encoder8to3_if.sv
// rtl/event_encoder8to3_if.sv - event encoder producer/consumer bundle
interface event_encoder8to3_if;
  logic [7:0] req;
  logic       clr;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  modport master (
    output req, clr, ready,
    input  code, valid, pending, overflow
  );

  modport slave (
    input  req, clr, ready,
    output code, valid, pending, overflow
  );
endinterface

// File: rtl/event_encoder8to3.sv
// rtl/event_encoder8to3.sv - priority event encoder with pending set and output register
module event_encoder8to3 #(
  parameter bit LSB_FIRST = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  event_encoder8to3_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;

  logic [7:0] cand;
  logic [7:0] code_mask;
  logic [2:0] sel;
  logic       load;
  logic       dup_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      code_q     <= 3'b000;
      pending_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Later loop iterations overwrite earlier ones, so scan order sets priority.
  always_comb begin
    sel = 3'b000;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (cand[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (cand[i]) sel = 3'(i);
      end
    end
  end

  always_comb begin
    cand      = pending_q | bus.req;
    code_mask = 8'(1) << code_q;
    load      = (state_q == EMPTY) || bus.ready;
    // A repeat of the event still sitting unconsumed in code is merged into it.
    dup_held  = (state_q == FULL) && !bus.ready && |(bus.req & code_mask);

    state_d    = state_q;
    code_d     = code_q;
    pending_d  = dup_held ? (cand & ~code_mask) : cand;
    overflow_d = overflow_q | (|(bus.req & pending_q)) | dup_held;

    if (bus.clr) begin
      state_d    = EMPTY;
      pending_d  = 8'h00;
      overflow_d = 1'b0;
    end else if (load) begin
      if (cand != 8'h00) begin
        state_d   = FULL;
        code_d    = sel;
        pending_d = cand & ~(8'(1) << sel);
      end else begin
        state_d = EMPTY;
      end
    end
  end

  assign bus.code     = code_q;
  assign bus.valid    = (state_q == FULL);
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/event_encoder8to3.md
EVENT_ENCODER8TO3 -- requirements
Module: event_encoder8to3

Interface
REQ-001 Parameter LSB_FIRST, default 0; 0 = bit 7 highest priority, 1 = bit 0 highest priority.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  one-hot-or-multi event lines; each high bit for one cycle = one event.
REQ-005 clr  input  1  synchronous flush of all pending, output and sticky state.
REQ-006 code  output  3  encoded index of the event presented; meaningful only while valid=1.
REQ-007 valid  output  1  code holds an unconsumed event.
REQ-008 ready  input  1  consumer accepts code when valid&ready at a rising edge.
REQ-009 pending  output  8  events captured but not yet moved to the output register.
REQ-010 overflow  output  1  sticky; an event arrived on an index already pending or held in code.

Function
REQ-011 Block SHALL have two states: EMPTY (valid=0) and FULL (valid=1).
REQ-012 Candidate set each cycle SHALL be cand = pending | req.
REQ-013 Load condition SHALL be load = (state EMPTY) or (valid & ready).
REQ-014 On load with cand != 0, the block SHALL set code to the highest-priority index in cand per LSB_FIRST, set valid=1 and exclude that bit from the next pending.
REQ-015 On load with cand == 0, the block SHALL set valid=0, with code holding its last value.
REQ-016 Without load, code and valid SHALL hold; the next pending SHALL equal cand.
REQ-017 With load, the next pending SHALL equal cand with the selected bit cleared.
REQ-018 Latency: req bit in cycle N with state EMPTY SHALL give valid=1 with the matching code in cycle N+1.
REQ-019 Back-to-back: with valid&ready and cand != 0 in the same cycle, valid SHALL stay 1 and code SHALL change to the next index with no bubble.
REQ-020 Throughput SHALL be one event per cycle while ready=1.
REQ-021 overflow SHALL set when req[i]=1 and pending[i]=1 in the same cycle.
REQ-022 overflow SHALL also set when req[i]=1, valid=1, code=i and the output is not consumed that cycle.
REQ-023 The duplicate event in REQ-021/REQ-022 SHALL be merged, not queued.
REQ-024 overflow SHALL clear only on clr or reset.
REQ-025 clr=1 SHALL have priority over all other activity: next pending=0, valid=0, overflow=0, and req in that cycle ignored.
REQ-026 A ready=1 while valid=0 SHALL have no effect.
REQ-027 The block SHALL be fully synchronous except for rst_n, with no combinational path from req to valid or code.

Reset
REQ-028 rst_n low SHALL immediately force pending=8'h00, valid=0, code=3'b000 and overflow=0, regardless of clk.
REQ-029 Assertion mid-operation SHALL discard all captured events.
REQ-030 After deassertion, the first capture SHALL occur at the first rising edge with rst_n high.
REQ-031 While rst_n is low, req, ready and clr SHALL be ignored.

Verification
REQ-032 Single event, ready=1, LSB_FIRST=0: req=8'h20 for 1 cycle -> next cycle valid=1, code=5; following cycle valid=0, pending=0.
REQ-033 Multi event, ready=1: req=8'hA5 for 1 cycle -> code sequence 7,5,2,0 on consecutive cycles, then valid=0; with LSB_FIRST=1 the sequence is 0,2,5,7.
REQ-034 Backpressure: req=8'h03, ready=0 for 4 cycles -> valid=1, code=1, pending=8'h01 held stable; ready=1 -> code=0 next cycle, then valid=0.
REQ-035 Overflow: ready=0, req=8'h10 twice in two consecutive cycles -> overflow=1, only one code=4 delivered; clr pulse -> overflow=0, valid=0, pending=0.
REQ-036 Async reset mid-stream: req=8'hFF, then rst_n low between edges -> outputs zero immediately; after release with req=0 -> valid stays 0.
REQ-037 Simultaneous clr and req: clr=1, req=8'h08 -> next cycle valid=0, pending=0, overflow=0.
